// File: rtl/freq_channel.sv
// freq_channel: reciprocal frequency counter; counts clk_i cycles over N periods of async fin_i.
// Latency: results and ready_o appear one cycle after the target-th rise; the 2-flop sync delays every edge equally.
// No backpressure: start_i is ignored while busy, stop_i aborts silently. Option: FREQ_CHANNEL_GLITCH_FILTER_EN.

module freq_channel #(
    parameter int CNT_W = 32,
    parameter int PER_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fin_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [PER_W-1:0] periods_i,
    output logic [CNT_W-1:0] cnt_ref_o,
    output logic [PER_W-1:0] cnt_per_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             ovf_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    // Cycles after reset until the edge detector compares two genuinely sampled levels.
`ifdef FREQ_CHANNEL_GLITCH_FILTER_EN
    localparam logic [2:0] PRIME_N = 3'd5;
`else
    localparam logic [2:0] PRIME_N = 3'd3;
`endif

    localparam logic [CNT_W-1:0] REF_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] REF_MAX = {CNT_W{1'b1}};
    localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [2:0] prime_q, prime_d;
    logic       lvl_cur;
    logic       lvl_prev;
    logic       rise;

    // Two-flop synchronizer plus a warm-up counter that masks the reset-to-first-sample transition.
    always_comb begin
        sync1_d = fin_i;
        sync2_d = sync1_q;
        prime_d = (prime_q == PRIME_N) ? prime_q : prime_q + 3'd1;
    end

    // Synchronizer and warm-up registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prime_q <= 3'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prime_q <= prime_d;
        end
    end

`ifdef FREQ_CHANNEL_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;

    // Filter level follows the synchronized input only after three equal consecutive samples.
    always_comb begin
        hist_d = {hist_q[0], sync2_q};
        filt_d = filt_q;
        if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
            filt_d = sync2_q;
        end
    end

    // Filter history and output level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    // Edge taken on the filter's next value so every edge sees exactly two extra cycles.
    assign lvl_cur  = filt_d;
    assign lvl_prev = filt_q;
`else
    logic prev_q, prev_d;

    // Previous synchronized level for edge detection.
    always_comb begin
        prev_d = sync2_q;
    end

    // Edge-detect history register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign lvl_cur  = sync2_q;
    assign lvl_prev = prev_q;
`endif

    assign rise = lvl_cur & ~lvl_prev & (prime_q == PRIME_N);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_ref_q, cnt_ref_d;
    logic [PER_W-1:0] cnt_per_q, cnt_per_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] ref_inc;
    logic [PER_W-1:0] per_inc;
    logic             sat;

    assign ref_inc = ref_q + REF_ONE;
    assign per_inc = per_q + PER_ONE;
    // Saturate on the cycle the counter would become all-ones; that value is the reported count.
    assign sat     = (ref_inc == REF_MAX);

    // Measurement FSM: stop beats saturation, saturation beats rise.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        per_d     = per_q;
        tgt_d     = tgt_q;
        cnt_ref_d = cnt_ref_q;
        cnt_per_d = cnt_per_q;
        ovf_d     = ovf_q;
        ready_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stop_i && start_i && (periods_i != '0)) begin
                    state_d = ST_ARM;
                    tgt_d   = periods_i;
                    ref_d   = '0;
                end
            end
            ST_ARM: begin
                ref_d = ref_inc;
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (sat) begin
                    cnt_ref_d = REF_MAX;
                    cnt_per_d = '0;
                    ovf_d     = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rise) begin
                    ref_d   = '0;
                    per_d   = '0;
                    state_d = ST_MEAS;
                end
            end
            ST_MEAS: begin
                ref_d = ref_inc;
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (sat) begin
                    cnt_ref_d = REF_MAX;
                    cnt_per_d = per_q;
                    ovf_d     = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rise) begin
                    per_d = per_inc;
                    if (per_inc == tgt_q) begin
                        cnt_ref_d = ref_inc;
                        cnt_per_d = per_inc;
                        ovf_d     = 1'b0;
                        ready_d   = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counters and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ref_q     <= '0;
            per_q     <= '0;
            tgt_q     <= '0;
            cnt_ref_q <= '0;
            cnt_per_q <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            per_q     <= per_d;
            tgt_q     <= tgt_d;
            cnt_ref_q <= cnt_ref_d;
            cnt_per_q <= cnt_per_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
        end
    end

    assign cnt_ref_o = cnt_ref_q;
    assign cnt_per_o = cnt_per_q;
    assign ovf_o     = ovf_q;
    assign ready_o   = ready_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule
